vp_bin_thresh: RTL and testbench

VP_BIN_THRESH -- requirements
Module: vp_bin_thresh

---
 rtl/vp_bin_thresh.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_vp_bin_thresh.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vp_bin_thresh.sv
// -----------------------------------------------------------------------------
// vp_bin_thresh
// Binarising threshold stage for a streaming video pipeline. Each channel of
// the incoming pixel is tested against an inclusive [lo, hi] window. The
// per-channel hits are combined (AND / OR / majority), optionally inverted,
// and the pixel is replaced by all ones or all zeros. Bypass mode passes the
// pixel through with the same latency. A per-frame foreground counter reports
// how many binarised pixels were 1 in the last completed frame.
//
// Configuration is double-buffered: cfg_valid loads a pending set, which is
// promoted to the active set at the next frame boundary (v_sync_in rising).
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   pixel_in            N_CH packed channels, channel i at [(i+1)*CH_W-1 : i*CH_W]
//   de_in/h_sync_in/v_sync_in  input video timing
//   th_lo, th_hi        per-channel window bounds (same packing as pixel_in)
//   mode                00 AND, 01 OR, 10 majority, 11 bypass
//   invert              invert the binary result (ignored in bypass)
//   cfg_valid           strobe sampling th_lo/th_hi/mode/invert
//   pixel_out           binarised (or bypassed) pixel, 2 cycles after input
//   de_out/h_sync_out/v_sync_out  timing aligned with pixel_out
//   fg_count            foreground count of the last completed frame
//   fg_count_valid      one-cycle pulse when fg_count updates
//   cfg_pending         a sampled configuration awaits the next frame boundary
// -----------------------------------------------------------------------------
module vp_bin_thresh #(
    parameter int CH_W  = 8,
    parameter int N_CH  = 3,
    parameter int CNT_W = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*CH_W-1:0]   pixel_in,
    input  logic                   de_in,
    input  logic                   h_sync_in,
    input  logic                   v_sync_in,
    input  logic [N_CH*CH_W-1:0]   th_lo,
    input  logic [N_CH*CH_W-1:0]   th_hi,
    input  logic [1:0]             mode,
    input  logic                   invert,
    input  logic                   cfg_valid,
    output logic [N_CH*CH_W-1:0]   pixel_out,
    output logic                   de_out,
    output logic                   h_sync_out,
    output logic                   v_sync_out,
    output logic [CNT_W-1:0]       fg_count,
    output logic                   fg_count_valid,
    output logic                   cfg_pending
);

    localparam int PW = N_CH * CH_W;

    // Saturating increment of the foreground accumulator.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a,
                                                 input logic             inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{CNT_W{1'b0}}, inc};
        if (sum[CNT_W]) begin
            sat_inc = {CNT_W{1'b1}};
        end else begin
            sat_inc = sum[CNT_W-1:0];
        end
    endfunction

    // Strict majority of the channel hits (more than half, integer division).
    function automatic logic majority(input logic [N_CH-1:0] h);
        int pop;
        pop = 0;
        for (int i = 0; i < N_CH; i++) begin
            if (h[i]) begin
                pop = pop + 1;
            end else begin
                pop = pop + 0;
            end
        end
        majority = (pop > (N_CH / 2));
    endfunction

    // ---------------- configuration shadowing ----------------
    logic            vs_prev_q;
    logic            frame_edge;
    logic [PW-1:0]   pend_lo_q, pend_lo_d, pend_hi_q, pend_hi_d;
    logic [1:0]      pend_mode_q, pend_mode_d;
    logic            pend_inv_q, pend_inv_d;
    logic            cfg_pending_q, cfg_pending_d;
    logic [PW-1:0]   act_lo_q, act_lo_d, act_hi_q, act_hi_d;
    logic [1:0]      act_mode_q, act_mode_d;
    logic            act_inv_q, act_inv_d;

    assign frame_edge = v_sync_in & ~vs_prev_q;

    // Pending/active configuration update: a cfg_valid landing on the boundary
    // bypasses the pending set and goes straight to the active registers.
    always_comb begin
        pend_lo_d     = pend_lo_q;
        pend_hi_d     = pend_hi_q;
        pend_mode_d   = pend_mode_q;
        pend_inv_d    = pend_inv_q;
        cfg_pending_d = cfg_pending_q;
        act_lo_d      = act_lo_q;
        act_hi_d      = act_hi_q;
        act_mode_d    = act_mode_q;
        act_inv_d     = act_inv_q;
        if (frame_edge) begin
            if (cfg_valid) begin
                act_lo_d   = th_lo;
                act_hi_d   = th_hi;
                act_mode_d = mode;
                act_inv_d  = invert;
            end else if (cfg_pending_q) begin
                act_lo_d   = pend_lo_q;
                act_hi_d   = pend_hi_q;
                act_mode_d = pend_mode_q;
                act_inv_d  = pend_inv_q;
            end else begin
                act_lo_d   = act_lo_q;
            end
            cfg_pending_d = 1'b0;
        end else if (cfg_valid) begin
            pend_lo_d     = th_lo;
            pend_hi_d     = th_hi;
            pend_mode_d   = mode;
            pend_inv_d    = invert;
            cfg_pending_d = 1'b1;
        end else begin
            cfg_pending_d = cfg_pending_q;
        end
    end

    // Configuration registers; the input vsync history resets high so a
    // vsync already asserted at reset release is not taken as a boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev_q     <= 1'b1;
            pend_lo_q     <= {PW{1'b0}};
            pend_hi_q     <= {PW{1'b0}};
            pend_mode_q   <= 2'b00;
            pend_inv_q    <= 1'b0;
            cfg_pending_q <= 1'b0;
            act_lo_q      <= {PW{1'b0}};
            act_hi_q      <= {PW{1'b1}};
            act_mode_q    <= 2'b00;
            act_inv_q     <= 1'b0;
        end else begin
            vs_prev_q     <= v_sync_in;
            pend_lo_q     <= pend_lo_d;
            pend_hi_q     <= pend_hi_d;
            pend_mode_q   <= pend_mode_d;
            pend_inv_q    <= pend_inv_d;
            cfg_pending_q <= cfg_pending_d;
            act_lo_q      <= act_lo_d;
            act_hi_q      <= act_hi_d;
            act_mode_q    <= act_mode_d;
            act_inv_q     <= act_inv_d;
        end
    end

    // ---------------- stage 1: window compare ----------------
    logic [N_CH-1:0] hit_d, s1_hit_q;
    logic [PW-1:0]   s1_pix_q;
    logic            s1_de_q, s1_hs_q, s1_vs_q, s1_edge_q, s1_inv_q;
    logic [1:0]      s1_mode_q;

    // Per-channel inclusive window test; an inverted window (lo > hi) never hits.
    always_comb begin
        hit_d = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            hit_d[i] = (pixel_in[i*CH_W +: CH_W] >= act_lo_q[i*CH_W +: CH_W]) &&
                       (pixel_in[i*CH_W +: CH_W] <= act_hi_q[i*CH_W +: CH_W]);
        end
    end

    // Stage-1 registers; mode/invert travel with the pixel so a boundary
    // never changes the treatment of pixels already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_hit_q  <= {N_CH{1'b0}};
            s1_pix_q  <= {PW{1'b0}};
            s1_de_q   <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s1_edge_q <= 1'b0;
            s1_mode_q <= 2'b00;
            s1_inv_q  <= 1'b0;
        end else begin
            s1_hit_q  <= hit_d;
            s1_pix_q  <= pixel_in;
            s1_de_q   <= de_in;
            s1_hs_q   <= h_sync_in;
            s1_vs_q   <= v_sync_in;
            s1_edge_q <= frame_edge;
            s1_mode_q <= act_mode_q;
            s1_inv_q  <= act_inv_q;
        end
    end

    // ---------------- stage 2: combine and output ----------------
    logic          comb_s, res_s, bypass_s, fg_inc_d;
    logic [PW-1:0] pix_out_d, pix_out_q;
    logic          de_out_q, hs_out_q, vs_out_q, s2_edge_q, s2_fg_q;

    // Hit combination, inversion and output pixel selection.
    always_comb begin
        comb_s   = 1'b0;
        bypass_s = (s1_mode_q == 2'b11);
        case (s1_mode_q)
            2'b00:   comb_s = &s1_hit_q;
            2'b01:   comb_s = |s1_hit_q;
            2'b10:   comb_s = majority(s1_hit_q);
            default: comb_s = 1'b0;
        endcase
        res_s = comb_s ^ s1_inv_q;
        if (!s1_de_q) begin
            pix_out_d = {PW{1'b0}};
        end else if (bypass_s) begin
            pix_out_d = s1_pix_q;
        end else begin
            pix_out_d = {PW{res_s}};
        end
        fg_inc_d = s1_de_q & ~bypass_s & res_s;
    end

    // Stage-2 output registers. The stage-2 vsync edge is the input boundary
    // flag carried down the pipe, which inherits the reset-high history and
    // therefore ignores a vsync held high across reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_out_q <= {PW{1'b0}};
            de_out_q  <= 1'b0;
            hs_out_q  <= 1'b0;
            vs_out_q  <= 1'b0;
            s2_edge_q <= 1'b0;
            s2_fg_q   <= 1'b0;
        end else begin
            pix_out_q <= pix_out_d;
            de_out_q  <= s1_de_q;
            hs_out_q  <= s1_hs_q;
            vs_out_q  <= s1_vs_q;
            s2_edge_q <= s1_edge_q;
            s2_fg_q   <= fg_inc_d;
        end
    end

    // ---------------- foreground counter ----------------
    logic [CNT_W-1:0] acc_q, acc_d, fg_count_q, fg_count_d, acc_sum_s;
    logic             fg_valid_q, fg_valid_d;

    // Accumulate foreground pixels; at the delayed vsync edge publish the
    // total including the edge cycle's own increment and restart.
    always_comb begin
        acc_sum_s = sat_inc(acc_q, s2_fg_q);
        if (s2_edge_q) begin
            fg_count_d = acc_sum_s;
            acc_d      = {CNT_W{1'b0}};
            fg_valid_d = 1'b1;
        end else begin
            fg_count_d = fg_count_q;
            acc_d      = acc_sum_s;
            fg_valid_d = 1'b0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= {CNT_W{1'b0}};
            fg_count_q <= {CNT_W{1'b0}};
            fg_valid_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            fg_count_q <= fg_count_d;
            fg_valid_q <= fg_valid_d;
        end
    end

    assign pixel_out      = pix_out_q;
    assign de_out         = de_out_q;
    assign h_sync_out     = hs_out_q;
    assign v_sync_out     = vs_out_q;
    assign fg_count       = fg_count_q;
    assign fg_count_valid = fg_valid_q;
    assign cfg_pending    = cfg_pending_q;

endmodule

// File: tb/tb_vp_bin_thresh.sv
module tb_vp_bin_thresh;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [23:0] pixel_in, th_lo, th_hi;
    logic        de_in, h_sync_in, v_sync_in;
    logic [1:0]  mode;
    logic        invert, cfg_valid;

    logic [23:0] pixel_out, pixel_out4;
    logic        de_out, h_sync_out, v_sync_out;
    logic        de_out4, h_sync_out4, v_sync_out4;
    logic [21:0] fg_count;
    logic [3:0]  fg_count4;
    logic        fg_count_valid, fg_count_valid4, cfg_pending, cfg_pending4;

    vp_bin_thresh #(.CH_W(8), .N_CH(3), .CNT_W(22)) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .de_in(de_in),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .th_lo(th_lo), .th_hi(th_hi),
        .mode(mode), .invert(invert), .cfg_valid(cfg_valid),
        .pixel_out(pixel_out), .de_out(de_out), .h_sync_out(h_sync_out),
        .v_sync_out(v_sync_out), .fg_count(fg_count),
        .fg_count_valid(fg_count_valid), .cfg_pending(cfg_pending)
    );

    vp_bin_thresh #(.CH_W(8), .N_CH(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .de_in(de_in),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .th_lo(th_lo), .th_hi(th_hi),
        .mode(mode), .invert(invert), .cfg_valid(cfg_valid),
        .pixel_out(pixel_out4), .de_out(de_out4), .h_sync_out(h_sync_out4),
        .v_sync_out(v_sync_out4), .fg_count(fg_count4),
        .fg_count_valid(fg_count_valid4), .cfg_pending(cfg_pending4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [23:0] pix;
        logic        de, hs, vs, vedge, fg;
    } ent_t;

    ent_t        q[$];
    logic [23:0] m_lo, m_hi, p_lo, p_hi;
    logic [1:0]  m_mode, p_mode;
    logic        m_inv, p_inv, m_pend, m_vprev, exp_valid_next;
    int          m_acc, exp_cnt;
    logic [31:0] last_fg, last_fg4;

    // Returns {foreground, output pixel} for one input pixel and configuration.
    function automatic logic [24:0] ref_out(input logic [23:0] pix, input logic de,
                                            input logic [23:0] lo, input logic [23:0] hi,
                                            input logic [1:0] md, input logic inv);
        int hits = 0;
        logic r;
        logic [7:0] c, l, h;
        for (int i = 0; i < 3; i++) begin
            c = pix[8*i +: 8]; l = lo[8*i +: 8]; h = hi[8*i +: 8];
            if (c >= l && c <= h) hits++;
        end
        if (md == 2'b11) return {1'b0, de ? pix : 24'h000000};
        case (md)
            2'b00:   r = (hits == 3);
            2'b01:   r = (hits > 0);
            default: r = (hits >= 2);
        endcase
        r = r ^ inv;
        return {de & r, de ? {24{r}} : 24'h000000};
    endfunction

    function automatic int sat22(input int v);
        return (v > 32'h3FFFFF) ? 32'h3FFFFF : v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_lo = 24'h000000; m_hi = 24'hFFFFFF; m_mode = 2'b00; m_inv = 1'b0;
        p_lo = 24'h000000; p_hi = 24'h000000; p_mode = 2'b00; p_inv = 1'b0;
        m_pend = 1'b0; m_vprev = 1'b1; exp_valid_next = 1'b0;
        m_acc = 0; exp_cnt = 0;
    endtask

    // One clock: record expectation for the current inputs, clock, then check.
    task automatic step();
        ent_t e;
        logic [24:0] r;
        logic ev;
        r = ref_out(pixel_in, de_in, m_lo, m_hi, m_mode, m_inv);
        ev = v_sync_in & ~m_vprev;
        e = '{pix: r[23:0], de: de_in, hs: h_sync_in, vs: v_sync_in, vedge: ev, fg: r[24]};
        q.push_back(e);
        @(posedge clk);
        #1;
        if (ev && cfg_valid) begin
            m_lo = th_lo; m_hi = th_hi; m_mode = mode; m_inv = invert; m_pend = 1'b0;
        end else if (ev && m_pend) begin
            m_lo = p_lo; m_hi = p_hi; m_mode = p_mode; m_inv = p_inv; m_pend = 1'b0;
        end else if (cfg_valid) begin
            p_lo = th_lo; p_hi = th_hi; p_mode = mode; p_inv = invert; m_pend = 1'b1;
        end
        m_vprev = v_sync_in;
        check("cfg_pending", {31'd0, cfg_pending}, {31'd0, m_pend});
        check("fg_valid", {31'd0, fg_count_valid}, {31'd0, exp_valid_next});
        check("fg_valid_w4", {31'd0, fg_count_valid4}, {31'd0, exp_valid_next});
        if (exp_valid_next) begin
            check("fg_count", {10'd0, fg_count}, 32'(exp_cnt));
            check("fg_count_w4", {28'd0, fg_count4}, (exp_cnt > 15) ? 32'd15 : 32'(exp_cnt));
            last_fg  = {10'd0, fg_count};
            last_fg4 = {28'd0, fg_count4};
        end
        exp_valid_next = 1'b0;
        if (q.size() == 2) begin
            e = q.pop_front();
            check("pixel_out", {8'd0, pixel_out}, {8'd0, e.pix});
            check("de_out", {31'd0, de_out}, {31'd0, e.de});
            check("h_sync_out", {31'd0, h_sync_out}, {31'd0, e.hs});
            check("v_sync_out", {31'd0, v_sync_out}, {31'd0, e.vs});
            if (e.vedge) begin
                exp_cnt = sat22(m_acc + (e.fg ? 1 : 0));
                m_acc = 0;
                exp_valid_next = 1'b1;
            end else begin
                m_acc = sat22(m_acc + (e.fg ? 1 : 0));
            end
        end
    endtask

    task automatic drv(input logic [23:0] p, input logic de, input logic vs, input logic cv);
        pixel_in = p; de_in = de; v_sync_in = vs; cfg_valid = cv;
        h_sync_in = 1'($urandom_range(0, 1));
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic vsync(input logic cv_edge);
        drv(24'h000000, 1'b0, 1'b1, cv_edge);
        drv(24'h000000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drv(24'h000000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_cfg(input logic [23:0] lo, input logic [23:0] hi,
                           input logic [1:0] md, input logic inv);
        th_lo = lo; th_hi = hi; mode = md; invert = inv;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("rst_pixel_out", {8'd0, pixel_out}, 32'd0);
        check("rst_de_out", {31'd0, de_out}, 32'd0);
        check("rst_v_sync_out", {31'd0, v_sync_out}, 32'd0);
        check("rst_fg_count", {10'd0, fg_count}, 32'd0);
        check("rst_fg_valid", {31'd0, fg_count_valid}, 32'd0);
        check("rst_cfg_pending", {31'd0, cfg_pending}, 32'd0);
        rst = 1'b0;
    endtask

    function automatic logic [23:0] in_win();
        return {8'(8'h40 + $urandom_range(0, 64)), 8'(8'h40 + $urandom_range(0, 64)),
                8'(8'h40 + $urandom_range(0, 64))};
    endfunction

    function automatic logic [23:0] out_win();
        return {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 63))};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pixel_in = 24'h0; de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0;
        cfg_valid = 1'b0; last_fg = 32'd0; last_fg4 = 32'd0;
        set_cfg(24'h000000, 24'h000000, 2'b00, 1'b0);
        do_reset();

        // Reset configuration passes every pixel as foreground.
        drv(24'h123456, 1'b1, 1'b0, 1'b0);
        drv(24'h123456, 1'b1, 1'b0, 1'b0);
        check("default_pix", {8'd0, pixel_out}, 32'h00FFFFFF);
        check("default_de", {31'd0, de_out}, 32'd1);
        drv(24'h000000, 1'b0, 1'b0, 1'b0);
        vsync(1'b0);
        check("default_count", last_fg, 32'd2);

        // Shadowed AND window: pending until the edge.
        set_cfg(24'h404040, 24'h808080, 2'b00, 1'b0);
        drv(24'h000000, 1'b0, 1'b0, 1'b1);
        check("pending_set", {31'd0, cfg_pending}, 32'd1);
        drv(24'h608090, 1'b1, 1'b0, 1'b0);
        drv(24'h608070, 1'b1, 1'b0, 1'b0);
        check("shadow_old", {8'd0, pixel_out}, 32'h00FFFFFF);
        vsync(1'b0);
        check("pending_clr", {31'd0, cfg_pending}, 32'd0);
        drv(24'h608090, 1'b1, 1'b0, 1'b0);
        drv(24'h608070, 1'b1, 1'b0, 1'b0);
        check("and_miss", {8'd0, pixel_out}, 32'h00000000);
        drv(24'h000000, 1'b0, 1'b0, 1'b0);
        check("and_hit", {8'd0, pixel_out}, 32'h00FFFFFF);

        // Invert applied on the edge cycle itself.
        set_cfg(24'h404040, 24'h808080, 2'b00, 1'b1);
        vsync(1'b1);
        drv(24'h608090, 1'b1, 1'b0, 1'b0);
        drv(24'h608070, 1'b1, 1'b0, 1'b0);
        check("inv_miss", {8'd0, pixel_out}, 32'h00FFFFFF);
        drv(24'h000000, 1'b0, 1'b0, 1'b0);
        check("inv_hit", {8'd0, pixel_out}, 32'h00000000);

        // Majority then OR.
        set_cfg(24'h404040, 24'h808080, 2'b10, 1'b0);
        vsync(1'b1);
        drv(24'h60FF70, 1'b1, 1'b0, 1'b0);
        drv(24'h60FFFF, 1'b1, 1'b0, 1'b0);
        check("maj_2of3", {8'd0, pixel_out}, 32'h00FFFFFF);
        drv(24'h000000, 1'b0, 1'b0, 1'b0);
        check("maj_1of3", {8'd0, pixel_out}, 32'h00000000);
        set_cfg(24'h404040, 24'h808080, 2'b01, 1'b0);
        vsync(1'b1);
        drv(24'h60FFFF, 1'b1, 1'b0, 1'b0);
        drv(24'h000000, 1'b0, 1'b0, 1'b0);
        check("or_1of3", {8'd0, pixel_out}, 32'h00FFFFFF);

        // 100 foreground out of 300 active pixels.
        set_cfg(24'h404040, 24'h808080, 2'b00, 1'b0);
        vsync(1'b1);
        for (int i = 0; i < 300; i++) drv((i % 3 == 0) ? in_win() : out_win(), 1'b1, 1'b0, 1'b0);
        vsync(1'b0);
        check("count_100", last_fg, 32'd100);

        // 20 foreground saturates the 4-bit counter.
        for (int i = 0; i < 20; i++) drv(in_win(), 1'b1, 1'b0, 1'b0);
        vsync(1'b0);
        check("count_20", last_fg, 32'd20);
        check("count_sat4", last_fg4, 32'd15);

        // Bypass frame counts nothing.
        set_cfg(24'h404040, 24'h808080, 2'b11, 1'b1);
        vsync(1'b1);
        for (int i = 0; i < 50; i++) drv(24'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        vsync(1'b0);
        check("count_bypass", last_fg, 32'd0);

        // Randomised frames with random configuration strobes.
        for (int f = 0; f < 8; f++) begin
            set_cfg(24'($urandom), 24'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            vsync(1'($urandom_range(0, 1)));
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 40) == 0)
                    set_cfg(24'($urandom), 24'($urandom), 2'($urandom_range(0, 3)),
                            1'($urandom_range(0, 1)));
                drv(24'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0,
                    1'($urandom_range(0, 40) == 0));
            end
        end
        vsync(1'b0);

        // Reset mid-frame with vsync held high across release.
        set_cfg(24'h404040, 24'h808080, 2'b00, 1'b0);
        vsync(1'b1);
        for (int i = 0; i < 50; i++) drv(in_win(), 1'b1, 1'b0, 1'b0);
        v_sync_in = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) drv(24'h000000, 1'b0, 1'b1, 1'b0);
        drv(24'h000000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drv(24'($urandom), 1'b1, 1'b0, 1'b0);
        vsync(1'b0);
        check("count_after_rst", last_fg, 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
